// File: rtl/uart8_rx_buffer.sv
// ============================================================================
//  Module   : uart8_rx_buffer
//  Purpose  : Byte FIFO behind a UART receiver. It detects the rising edges of
//             rx_done and rx_err, stores bytes first-word fall-through, and
//             keeps a sticky overflow flag and a saturating error count.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart8_rx_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_done,
    input  logic              rx_err,
    input  logic [7:0]        rx_data,
    input  logic              m_ready,
    input  logic              clr_status,
    output logic              m_valid,
    output logic [7:0]        m_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W:0] c_FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);
    localparam logic [7:0]      c_ERR_MAX    = 8'hFF;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_done_q;
    logic              r_err_q;
    logic              r_overflow;
    logic [7:0]        r_err_count;

    logic w_push_req;
    logic w_err_evt;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_push_req = rx_done & ~r_done_q;
    assign w_err_evt  = rx_err & ~r_err_q;
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = ~w_empty & m_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // Edge-detect registers; reset high so levels already present at release are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q <= 1'b1;
            r_err_q  <= 1'b1;
        end else begin
            r_done_q <= rx_done;
            r_err_q  <= rx_err;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // clr_status wins over a same-cycle drop or error event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else if (clr_status) begin
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_err_evt && (r_err_count != c_ERR_MAX)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign m_valid   = ~w_empty;
    assign m_data    = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_uart8_rx_buffer.sv
// ============================================================================
//  Module   : tb_uart8_rx_buffer
//  Purpose  : Directed self-checking bench for uart8_rx_buffer (DEPTH = 16).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart8_rx_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic       rx_err;
    logic [7:0] rx_data;
    logic       m_ready;
    logic       clr_status;
    logic       m_valid;
    logic [7:0] m_data;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] err_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    uart8_rx_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .rx_data    (rx_data),
        .m_ready    (m_ready),
        .clr_status (clr_status),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .count      (count),
        .full       (full),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
        m_ready = 1'b0; clr_status = 1'b0;
        step(); step();
        check("rst_count", count, 0);
        check("rst_valid", m_valid, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_errcnt", err_count, 0);
        rst = 1'b0;
        step();

        // Long rx_done level pushes once
        rx_data = 8'hA5; rx_done = 1'b1;
        step();
        check("s1_valid_n1", m_valid, 1);
        check("s1_count_n1", count, 1);
        check("s1_data_n1", m_data, 8'hA5);
        for (int i = 0; i < 15; i++) step();
        check("s1_count_hold", count, 1);
        check("s1_data_hold", m_data, 8'hA5);
        rx_done = 1'b0; step();
        m_ready = 1'b1; step();
        m_ready = 1'b0;
        check("s1_pop_count", count, 0);
        check("s1_pop_valid", m_valid, 0);

        // Fill, overflow, drain
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        check("s2_count_full", count, 16);
        check("s2_full", full, 1);
        check("s2_ovf_before", overflow, 0);
        push_byte(8'h11);
        check("s2_count_after_drop", count, 16);
        check("s2_ovf_set", overflow, 1);
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("s2_drain_data", m_data, i);
            step();
        end
        m_ready = 1'b0;
        check("s2_drained_valid", m_valid, 0);
        check("s2_drained_count", count, 0);
        check("s2_ovf_sticky", overflow, 1);

        clr_status = 1'b1; step(); clr_status = 1'b0;
        check("clr_ovf", overflow, 0);

        // Push into full FIFO coincident with a pop
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        check("s3_full", full, 1);
        rx_data = 8'h55; rx_done = 1'b1; m_ready = 1'b1;
        check("s3_head", m_data, 8'h20);
        step();
        rx_done = 1'b0; m_ready = 1'b0;
        check("s3_count", count, 16);
        check("s3_ovf", overflow, 0);
        step();
        m_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("s3_drain_data", m_data, 8'h20 + i);
            step();
        end
        check("s3_last_data", m_data, 8'h55);
        step();
        m_ready = 1'b0;
        check("s3_empty", m_valid, 0);

        // Error counting and saturation
        push_byte(8'h66);
        push_byte(8'h77);
        rx_err = 1'b1; step(); rx_err = 1'b0; step();
        check("s4_err_one", err_count, 1);
        check("s4_err_no_push", count, 2);
        rx_err = 1'b1; for (int i = 0; i < 20; i++) step(); rx_err = 1'b0; step();
        check("s4_err_level_once", err_count, 2);
        for (int i = 0; i < 298; i++) begin
            rx_err = 1'b1; step(); rx_err = 1'b0; step();
        end
        check("s4_err_sat", err_count, 255);
        check("s4_count_kept", count, 2);
        rx_err = 1'b1; clr_status = 1'b1; step();
        clr_status = 1'b0; rx_err = 1'b0; step();
        check("s4_clr_errcnt", err_count, 0);
        check("s4_clr_ovf", overflow, 0);
        check("s4_clr_count", count, 2);
        check("s4_clr_head", m_data, 8'h66);
        rx_err = 1'b1; step(); rx_err = 1'b0; step();
        check("s4_err_after_clr", err_count, 1);

        // Reset mid-operation with rx_done held high
        push_byte(8'h88); push_byte(8'h99); push_byte(8'hAA);
        check("s5_count5", count, 5);
        rx_data = 8'hBB; rx_done = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        check("s5_rst_count", count, 0);
        check("s5_rst_valid", m_valid, 0);
        check("s5_rst_errcnt", err_count, 0);
        for (int i = 0; i < 4; i++) step();
        check("s5_no_push_held", count, 0);
        rx_done = 1'b0; step();
        rx_data = 8'hCC; rx_done = 1'b1; step();
        rx_done = 1'b0;
        check("s5_new_edge_count", count, 1);
        check("s5_new_edge_data", m_data, 8'hCC);
        step();

        // Coincident push/pop at mid occupancy keeps order
        push_byte(8'hDD);
        check("mid_count2", count, 2);
        rx_data = 8'hEE; rx_done = 1'b1; m_ready = 1'b1;
        step();
        rx_done = 1'b0; m_ready = 1'b0;
        check("mid_count_same", count, 2);
        check("mid_head", m_data, 8'hDD);
        m_ready = 1'b1; step(); m_ready = 1'b0;
        check("mid_next", m_data, 8'hEE);
        check("mid_count1", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart8_rx_buffer.md
UART8_RX_BUFFER -- requirements
Module: uart8_rx_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving FIFO depth in bytes; legal values are powers of two from 2 to 256.
REQ-002 The block SHALL have parameter ADDR_W, default 4, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, the same 16x-oversample tick that drives the receiver.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rx_done, input, 1 bit: receiver frame-complete level, high for one baud interval.
REQ-006 The block SHALL have port rx_err, input, 1 bit: receiver error level.
REQ-007 The block SHALL have port rx_data, input, 8 bits: receiver parallel byte, valid while rx_done is high.
REQ-008 The block SHALL have port m_ready, input, 1 bit: consumer accepts the head byte.
REQ-009 The block SHALL have port clr_status, input, 1 bit: one-cycle pulse that clears overflow and err_count.
REQ-010 The block SHALL have port m_valid, output, 1 bit: head byte available.
REQ-011 The block SHALL have port m_data, output, 8 bits: head byte (first-word fall-through).
REQ-012 The block SHALL have port count, output, ADDR_W+1 bits: number of stored bytes, 0..DEPTH.
REQ-013 The block SHALL have port full, output, 1 bit: high when count == DEPTH.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag for a dropped byte.
REQ-015 The block SHALL have port err_count, output, 8 bits: saturating count of receiver error events.

Function
REQ-016 The block SHALL register rx_done and rx_err once (done_q, err_q) for edge detection; push_req = rx_done & !done_q, err_evt = rx_err & !err_q.
REQ-017 The block SHALL push exactly one byte per rx_done rising edge, regardless of how long rx_done stays high; rx_data SHALL be sampled in the push_req cycle.
REQ-018 Push latency: when push_req occurs in cycle N into an empty FIFO, m_valid SHALL be 1 and m_data SHALL equal rx_data(N) in cycle N+1.
REQ-019 Pop SHALL occur when m_valid && m_ready; the read pointer advances and the next byte (or m_valid=0 if emptied) SHALL be presented in the following cycle.
REQ-020 m_valid SHALL equal (count != 0); m_data SHALL be don't-care when m_valid is 0, and m_ready SHALL be ignored in that case.
REQ-021 When full and push_req arrive without a pop, the byte SHALL be dropped, pointers and count SHALL be unchanged, and overflow SHALL be set to 1.
REQ-022 When full, push_req and pop coincide, the push SHALL be accepted, count SHALL remain DEPTH, and overflow SHALL be unchanged.
REQ-023 When not full and not empty, a coincident push and pop SHALL leave count unchanged and preserve byte order.
REQ-024 Pointers SHALL be ADDR_W bits and wrap modulo DEPTH; count SHALL be derived without overflow at DEPTH.
REQ-025 err_evt SHALL increment err_count by 1, saturating at 255 (no wrap).
REQ-026 clr_status SHALL take priority: in a clr_status cycle, overflow SHALL become 0 and err_count SHALL become 0, and any coincident err_evt or overflow event in that cycle SHALL be lost.
REQ-027 FIFO contents and pointers SHALL be unaffected by clr_status.
REQ-028 An rx_err level without an rx_done edge SHALL NOT push data; rx_done and rx_err SHALL be handled independently.

Reset
REQ-029 On rst=1 at a clk edge: read/write pointers=0, count=0, m_valid=0, full=0, overflow=0, err_count=0.
REQ-030 On reset, done_q and err_q SHALL be set to 1, so that levels already high when rst deasserts SHALL NOT register as events.
REQ-031 rst mid-operation SHALL discard all stored bytes; memory contents need not be cleared.
REQ-032 rst SHALL override clr_status, push and pop in the same cycle.

Verification
REQ-033 Scenario 1: hold rx_done=1 for 16 cycles with rx_data=0xA5 and m_ready=0 -> count=1, m_valid=1 from the next cycle, m_data=0xA5.
REQ-034 Scenario 2: push 0x01..0x10 (16 bytes), then push 0x11 -> full=1, count=16, overflow=1; then drain with m_ready=1 -> data 0x01..0x10 in order, then m_valid=0.
REQ-035 Scenario 3: FIFO full, push 0x55 in the same cycle as a pop -> count stays 16, overflow stays 0, and 0x55 is read out last.
REQ-036 Scenario 4: 300 rx_err rising edges -> err_count=255; pulse clr_status -> err_count=0 and overflow=0, with count unchanged.
REQ-037 Scenario 5: assert rst while rx_done=1 and count=5, then release it with rx_done still 1 -> count=0, m_valid=0, and no push until the next rx_done rising edge.
